// File: rtl/gbuffer_write_arbiter_if.sv
// Write-side bundle between raster/shader producers, the arbiter and gbuffer_mgr.
// The arbiter takes the slave view; the producer/manager side takes the master view.
interface gbuffer_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int MASK_W  = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*MASK_W-1:0] req_mask;
  logic [NUM_REQ-1:0]        req_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [ADDR_W-1:0]         out_addr;
  logic [MASK_W-1:0]         out_mask;
  logic                      mgr_full;
  logic [IDX_W-1:0]          grant_id;
  logic                      frame_done;
  logic [15:0]               frame_cnt;

  modport slave (
    input  req_valid, req_addr, req_mask, req_last, out_ready, mgr_full,
    output req_ready, out_valid, out_addr, out_mask, grant_id, frame_done, frame_cnt
  );

  modport master (
    output req_valid, req_addr, req_mask, req_last, out_ready, mgr_full,
    input  req_ready, out_valid, out_addr, out_mask, grant_id, frame_done, frame_cnt
  );
endinterface

// File: rtl/gbuffer_write_arbiter.sv
// Round-robin arbiter sharing gbuffer_mgr's write port among NUM_REQ producers,
// dropping zero-mask beats and fencing each frame with a drain then a frame_done pulse.
module gbuffer_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 32,
  parameter int MASK_W       = 8,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gbuffer_write_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] done_vec;
  logic [CNT_W-1:0]   drain_cnt;
  logic               out_valid_q;
  logic [ADDR_W-1:0]  out_addr_q;
  logic [MASK_W-1:0]  out_mask_q;
  logic [IDX_W-1:0]   grant_id_q;
  logic [15:0]        frame_cnt_q;

  logic [NUM_REQ-1:0] eligible;
  logic               slot_free;
  logic               found;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W:0]     pos;
  logic [IDX_W-1:0]   cand;
  logic               accept;
  logic               drain_ok;
  logic [ADDR_W-1:0]  g_addr;
  logic [MASK_W-1:0]  g_mask;
  logic               g_last;

  // First eligible requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    eligible  = bus.req_valid & ~done_vec;
    slot_free = ~out_valid_q | bus.out_ready;
    found     = 1'b0;
    gidx      = '0;
    pos       = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos  = {1'b0, ptr} + (IDX_W + 1)'(k);
      cand = (pos >= NUM_REQ_W) ? IDX_W'(pos - NUM_REQ_W) : IDX_W'(pos);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  assign g_addr   = bus.req_addr[gidx*ADDR_W +: ADDR_W];
  assign g_mask   = bus.req_mask[gidx*MASK_W +: MASK_W];
  assign g_last   = bus.req_last[gidx];
  assign drain_ok = ~out_valid_q & ~bus.mgr_full;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (&done_vec) state_next = DRAIN;
      DRAIN:   if (drain_ok && drain_cnt == CNT_LAST) state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    accept         = (state == RUN) && slot_free && found;
    bus.req_ready  = accept ? (NUM_REQ'(1) << gidx) : '0;
    bus.frame_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= '0;
      done_vec    <= '0;
      drain_cnt   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_mask_q  <= '0;
      grant_id_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

      // Zero-mask beats are consumed here without ever occupying the output slot.
      if (accept) begin
        ptr        <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
        grant_id_q <= gidx;
        if (g_last) done_vec[gidx] <= 1'b1;
        if (g_mask != '0) begin
          out_valid_q <= 1'b1;
          out_addr_q  <= g_addr;
          out_mask_q  <= g_mask;
        end
      end

      case (state)
        DRAIN:   drain_cnt <= drain_ok ? drain_cnt + 1'b1 : '0;
        DONE: begin
          drain_cnt   <= '0;
          done_vec    <= '0;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end
        default: drain_cnt <= '0;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_gbuffer_write_arbiter.sv
// Directed bench for gbuffer_write_arbiter: rotation, mask drop, backpressure,
// frame fence timing, early-last exclusion and mid-frame reset.
module tb_gbuffer_write_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   exp_e [10] = '{1, 2, 3, 0, 2, 3, 0, 2, 3, 0};

  always #5 clk = ~clk;

  gbuffer_write_arbiter_if #(.NUM_REQ(4), .ADDR_W(32), .MASK_W(8)) bus ();

  gbuffer_write_arbiter #(
    .NUM_REQ(4), .ADDR_W(32), .MASK_W(8), .DRAIN_CYCLES(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic base_data();
    bus.req_addr = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    bus.req_mask = {8'h44, 8'h33, 8'h22, 8'h11};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.out_ready = 1'b0;
    bus.mgr_full  = 1'b0;
    base_data();
    tick();
    tick();
    settle();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_out_mask", bus.out_mask, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    chk("rst_req_ready", bus.req_ready, 0);

    // Round-robin with every requester valid.
    rst_n = 1'b1;
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    settle();
    for (int k = 0; k < 8; k++) begin
      chk("rr_ready", bus.req_ready, 64'(1) << (k % 4));
      tick();
      chk("rr_out_valid", bus.out_valid, 1);
      chk("rr_out_addr", bus.out_addr, 64'hA0 + 64'(k % 4));
      chk("rr_grant_id", bus.grant_id, 64'(k % 4));
    end
    bus.req_valid = '0;
    settle();
    chk("rr_idle_ready", bus.req_ready, 0);
    tick();
    chk("rr_idle_valid", bus.out_valid, 0);

    // Requester 2 alone: three zero-mask beats dropped, fourth forwarded.
    bus.req_valid = 4'b0100;
    for (int b = 0; b < 4; b++) begin
      bus.req_addr[2*32 +: 32] = 32'h200 + 32'(b);
      bus.req_mask[2*8 +: 8]   = (b < 3) ? 8'h00 : 8'hFF;
      settle();
      chk("drop_ready", bus.req_ready, 4'b0100);
      tick();
      chk("drop_out_valid", bus.out_valid, (b == 3) ? 1 : 0);
    end
    chk("drop_out_addr", bus.out_addr, 32'h203);
    chk("drop_out_mask", bus.out_mask, 8'hFF);

    // Backpressure holds the loaded beat; release grants in the same cycle.
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_addr[0 +: 32] = 32'hC0;
    bus.req_mask[0 +: 8]  = 8'h5A;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("bp_ready", bus.req_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_addr", bus.out_addr, 32'h203);
      chk("bp_out_mask", bus.out_mask, 8'hFF);
      tick();
    end
    bus.out_ready = 1'b1;
    settle();
    chk("bp_release_ready", bus.req_ready, 4'b0001);
    tick();
    chk("bp_next_valid", bus.out_valid, 1);
    chk("bp_next_addr", bus.out_addr, 32'hC0);
    chk("bp_next_mask", bus.out_mask, 8'h5A);
    chk("bp_next_grant", bus.grant_id, 0);
    bus.req_valid = '0;
    tick();
    chk("bp_drained", bus.out_valid, 0);

    // Frame fence: 3 beats each (last on the third), pointer starts at 1.
    base_data();
    bus.req_valid = 4'hF;
    bus.mgr_full  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus.req_last = (k >= 8) ? 4'hF : 4'h0;
      settle();
      chk("frame_ready", bus.req_ready, 64'(1) << ((1 + k) % 4));
      tick();
    end
    bus.req_last = '0;
    for (int j = 1; j <= 26; j++) begin
      bus.mgr_full = (j <= 10);
      settle();
      chk("fence_no_done", bus.frame_done, 0);
      chk("fence_no_ready", bus.req_ready, 0);
      tick();
    end
    settle();
    chk("fence_done_pulse", bus.frame_done, 1);
    chk("fence_done_ready", bus.req_ready, 0);
    chk("fence_cnt_before", bus.frame_cnt, 0);
    tick();
    chk("fence_done_clear", bus.frame_done, 0);
    chk("fence_cnt_after", bus.frame_cnt, 1);
    chk("fence_new_grant", bus.req_ready, 4'b0010);
    bus.req_valid = '0;
    tick();
    chk("fence_idle_valid", bus.out_valid, 0);

    // Requester 1 finishes early and drops out of the rotation.
    bus.req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      bus.req_last = (k >= 7) ? 4'hF : 4'b0010;
      settle();
      chk("early_ready", bus.req_ready, 64'(1) << exp_e[k]);
      tick();
      chk("early_grant", bus.grant_id, 64'(exp_e[k]));
    end

    // Park a beat under backpressure, let the fence reach DRAIN, then reset.
    bus.out_ready = 1'b0;
    settle();
    chk("park_ready", bus.req_ready, 0);
    chk("park_valid", bus.out_valid, 1);
    tick();
    chk("drain_valid", bus.out_valid, 1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_addr", bus.out_addr, 0);
    chk("mid_rst_out_mask", bus.out_mask, 0);
    chk("mid_rst_frame_cnt", bus.frame_cnt, 0);
    chk("mid_rst_frame_done", bus.frame_done, 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_last  = '0;
    settle();
    chk("post_rst_ready0", bus.req_ready, 4'b0001);
    tick();
    chk("post_rst_grant0", bus.grant_id, 0);
    chk("post_rst_addr0", bus.out_addr, 32'hA0);
    settle();
    chk("post_rst_ready1", bus.req_ready, 4'b0010);
    tick();
    chk("post_rst_grant1", bus.grant_id, 1);
    chk("post_rst_addr1", bus.out_addr, 32'hA1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gbuffer_write_arbiter.md
Name: gbuffer_write_arbiter

Overview:
Shares the single write port of gbuffer_mgr among NUM_REQ raster/shader producers using a round-robin policy. It registers one beat at a time toward the manager and drops beats whose coarse-shading mask is zero. It fences each frame: once every requester has delivered its last beat, it drains the manager and then pulses frame_done before the next frame is admitted.

Parameters:
NUM_REQ, 4, number of producers (2..8)
ADDR_W, 32, pixel address width
MASK_W, 8, VRS mask width
DRAIN_CYCLES, 16, consecutive cycles of mgr_full==0 with output empty required before a frame is declared complete (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_mask  in  NUM_REQ*MASK_W  packed VRS masks
req_last  in  NUM_REQ  beat is requester's final beat of the frame
out_valid  out  1  beat to gbuffer_mgr (in_valid)
out_ready  in  1  gbuffer_mgr in_ready
out_addr  out  ADDR_W  to gbuffer_mgr in_addr
out_mask  out  MASK_W  to gbuffer_mgr in_vrs_mask
mgr_full  in  1  gbuffer_mgr dbg_full
grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester
frame_done  out  1  one-cycle pulse at the end of the frame fence
frame_cnt  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset: every output 0, round-robin pointer 0, done_vec 0, drain counter 0, state RUN.
- States: RUN, DRAIN, DONE.
- RUN arbitration: eligible[i] = req_valid[i] & ~done_vec[i]. Slot free = ~out_valid | out_ready.
- When the slot is free, grant the first eligible requester searching from the pointer upward with wrap. req_ready is combinational, asserted only for that requester. req_ready is all-zero when the slot is not free or the state is not RUN.
- On acceptance: pointer <= granted+1 mod NUM_REQ; grant_id <= granted; if req_last, set done_vec[granted].
- Accepted beat with nonzero mask: out_valid<=1 and out_addr/out_mask are loaded next cycle (1-cycle latency).
- Accepted beat with mask==0: consumed and dropped. out_valid<=0 if the slot was vacated. Its req_last still counts.
- out_valid/out_addr/out_mask hold stable while out_valid & ~out_ready. Back-to-back throughput is 1 beat/cycle.
- mgr_full does not gate RUN; only out_ready backpressures.
- RUN->DRAIN in the cycle after done_vec becomes all-ones.
- DRAIN: counter increments when ~out_valid & ~mgr_full, and clears otherwise. Reaching DRAIN_CYCLES -> DONE.
- DONE (one cycle): frame_done=1, frame_cnt++, done_vec<=0, counter<=0, then -> RUN. The pointer is unchanged.
- Requester already done: req_ready stays 0 even when req_valid, until DONE clears done_vec.
- rst_n low mid-frame: immediate return to reset values next edge; an in-flight out beat is discarded.

Test Plan:
- NUM_REQ=4, all valid continuously with nonzero masks, out_ready=1 -> grants 0,1,2,3,0,... and 1 beat/cycle; out_addr equals the granted requester's address one cycle later.
- Requester 2 only, mask=0x00 for 3 beats then 0xFF -> 4 req_ready pulses, exactly 1 out_valid beat carrying the 4th address.
- out_ready held 0 for 5 cycles with beat A loaded -> out_addr/out_mask stable, req_ready all 0; release -> A consumed and the next grant fires in the same cycle.
- Each requester sends 3 beats, last flagged; mgr_full=1 for 10 cycles after the last accept, DRAIN_CYCLES=16 -> frame_done pulses exactly 16 cycles after mgr_full falls; frame_cnt=1; requester 0's early new-frame beats are not accepted before the pulse.
- Requester 1 asserts req_last early while others continue -> requester 1 is not granted again; the others keep rotating among 0,2,3.
- Reset asserted while out_valid=1 and in DRAIN -> next cycle all outputs 0, state RUN, frame_cnt 0; round-robin order restarts from 0.
